// File: rtl/result_wb_stage.sv
// Writeback result stage: picks one of NUM_SRC source words and extracts and extends
// load data. The result and its rd tag are held in a valid/ready output register.
module result_wb_stage #(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 4,
  parameter int LOAD_SRC = 1,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int OFF_W    = $clog2(WIDTH/8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         result_src,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [2:0]               funct3,
  input  logic [OFF_W-1:0]         byte_off,
  input  logic [4:0]               rd_in,
  input  logic                     reg_write_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [4:0]               rd_out,
  output logic                     reg_write_out,
  output logic                     sel_err,
  output logic                     misalign_err,
  output logic [CNT_W-1:0]         retire_count
);

  logic             capture;
  logic             handoff;
  logic             sel_ok;
  logic             is_load;
  logic             load_bad;
  logic             next_wr;
  logic             sel_set;
  logic             mis_set;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_result;

  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign handoff   = out_valid && out_ready && reg_write_out;
  assign load_word = src_data[LOAD_SRC*WIDTH +: WIDTH];
  assign shifted   = load_word >> {byte_off, 3'b000};
  assign is_load   = (result_src == SEL_W'(LOAD_SRC));

  // When NUM_SRC is not a power of two, some select codes match no source.
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (result_src == SEL_W'(i)) begin
        sel_word = src_data[i*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    case (funct3)
      3'b000: begin
        load_val      = {WIDTH{shifted[7]}};
        load_val[7:0] = shifted[7:0];
      end
      3'b100: begin
        load_val[7:0] = shifted[7:0];
      end
      3'b001: begin
        load_val       = {WIDTH{shifted[15]}};
        load_val[15:0] = shifted[15:0];
        load_bad       = byte_off[0];
      end
      3'b101: begin
        load_val[15:0] = shifted[15:0];
        load_bad       = byte_off[0];
      end
      3'b010: begin
        load_val       = {WIDTH{shifted[31]}};
        load_val[31:0] = shifted[31:0];
        load_bad       = |byte_off[1:0];
      end
      3'b110: begin
        load_val[31:0] = shifted[31:0];
        load_bad       = (WIDTH != 64) || (|byte_off[1:0]);
      end
      3'b011: begin
        // the shift amount is zero whenever this code is legal
        load_val = shifted;
        load_bad = (WIDTH != 64) || (|byte_off);
      end
      default: load_bad = 1'b1;
    endcase
  end

  always_comb begin
    next_result = '0;
    next_wr     = 1'b0;
    sel_set     = 1'b0;
    mis_set     = 1'b0;
    if (!sel_ok) begin
      sel_set = 1'b1;
    end else if (is_load) begin
      if (load_bad) begin
        mis_set = 1'b1;
      end else begin
        next_result = load_val;
        next_wr     = reg_write_in;
      end
    end else begin
      next_result = sel_word;
      next_wr     = reg_write_in;
    end
  end

  // The retire counter sees the handshake before flush clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      result        <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      sel_err       <= 1'b0;
      misalign_err  <= 1'b0;
      retire_count  <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (capture) begin
        result        <= next_result;
        rd_out        <= rd_in;
        reg_write_out <= next_wr;
        if (sel_set) sel_err      <= 1'b1;
        if (mis_set) misalign_err <= 1'b1;
      end

      if (handoff && (retire_count != {CNT_W{1'b1}}))
        retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_wb_stage.sv
// Directed bench for result_wb_stage with 3 sources and the load source at index 1.
// A second instance with a 2-bit retire counter covers saturation.
module tb_result_wb_stage;
  localparam int WIDTH    = 32;
  localparam int NUM_SRC  = 3;
  localparam int LOAD_SRC = 1;
  localparam int SEL_W    = 2;
  localparam int OFF_W    = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     in_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         result_src;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [2:0]               funct3;
  logic [OFF_W-1:0]         byte_off;
  logic [4:0]               rd_in;
  logic                     reg_write_in;

  logic              in_ready, out_valid, reg_write_out, sel_err, misalign_err;
  logic [WIDTH-1:0]  result;
  logic [4:0]        rd_out;
  logic [15:0]       retire_count;

  logic              s_in_ready, s_out_valid, s_reg_write_out, s_sel_err, s_misalign_err;
  logic [WIDTH-1:0]  s_result;
  logic [4:0]        s_rd_out;
  logic [1:0]        s_retire_count;

  result_wb_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .LOAD_SRC(LOAD_SRC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .result_src(result_src), .src_data(src_data), .funct3(funct3), .byte_off(byte_off),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out), .reg_write_out(reg_write_out), .sel_err(sel_err),
    .misalign_err(misalign_err), .retire_count(retire_count)
  );

  result_wb_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .LOAD_SRC(LOAD_SRC), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .result_src(result_src), .src_data(src_data), .funct3(funct3), .byte_off(byte_off),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .rd_out(s_rd_out), .reg_write_out(s_reg_write_out), .sel_err(s_sel_err),
    .misalign_err(s_misalign_err), .retire_count(s_retire_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] res;
    logic        exp_wr;
    logic        mis;
    logic        serr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int running;
    int sat;

    // sources: src2 = 0xCAFEF00D, load word = 0x80FF7F01, src0 = 0x00001234
    vecs[0]  = '{2'd1, 3'b000, 2'd1, 5'd1,  1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'd1, 3'b000, 2'd3, 5'd2,  1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'd1, 3'b100, 2'd3, 5'd3,  1'b1, 32'h00000080, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 3'b001, 2'd2, 5'd4,  1'b1, 32'hFFFF80FF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'd1, 3'b101, 2'd2, 5'd5,  1'b1, 32'h000080FF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 3'b010, 2'd0, 5'd6,  1'b1, 32'h80FF7F01, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'd1, 3'b100, 2'd2, 5'd7,  1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2'd1, 3'b001, 2'd0, 5'd8,  1'b1, 32'h00007F01, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 3'b011, 2'd3, 5'd9,  1'b1, 32'h00001234, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'd2, 3'b111, 2'd1, 5'd0,  1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{2'd0, 3'b000, 2'd0, 5'd12, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'd1, 3'b001, 2'd1, 5'd13, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{2'd1, 3'b010, 2'd2, 5'd14, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{2'd1, 3'b011, 2'd0, 5'd15, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{2'd1, 3'b110, 2'd0, 5'd16, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{2'd1, 3'b111, 2'd0, 5'd17, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{2'd3, 3'b000, 2'd0, 5'd18, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{2'd2, 3'b000, 2'd0, 5'd19, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1};

    reset        = 1'b1;
    flush        = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    result_src   = 2'd0;
    src_data     = {32'hCAFEF00D, 32'h80FF7F01, 32'h00001234};
    funct3       = 3'b000;
    byte_off     = 2'd0;
    rd_in        = 5'd5;
    reg_write_in = 1'b1;

    // reset held over two edges with a valid beat offered
    tick;
    tick;
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst rd_out", rd_out, 0);
    chk("rst reg_write_out", reg_write_out, 0);
    chk("rst sel_err", sel_err, 0);
    chk("rst misalign_err", misalign_err, 0);
    chk("rst retire_count", retire_count, 0);
    chk("rst in_ready", in_ready, 1);

    reset = 1'b0;
    tick;
    chk("first result", result, 32'h00001234);
    chk("first out_valid", out_valid, 1);
    chk("first rd_out", rd_out, 5);
    chk("first reg_write_out", reg_write_out, 1);
    chk("first retire_count", retire_count, 0);

    // streaming table at full throughput; each edge retires the previous beat
    running = 1;
    for (int i = 0; i < 18; i++) begin
      result_src   = vecs[i].sel;
      funct3       = vecs[i].f3;
      byte_off     = vecs[i].off;
      rd_in        = vecs[i].rd;
      reg_write_in = vecs[i].wr;
      tick;
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d reg_write_out", i), reg_write_out, vecs[i].exp_wr);
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d misalign_err", i), misalign_err, vecs[i].mis);
      chk($sformatf("vec%0d sel_err", i), sel_err, vecs[i].serr);
      if (vecs[i].exp_wr) chk($sformatf("vec%0d rd_out", i), rd_out, vecs[i].rd);
      chk($sformatf("vec%0d retire_count", i), retire_count, running);
      sat = (running > 3) ? 3 : running;
      chk($sformatf("vec%0d sat retire_count", i), s_retire_count, sat);
      if (vecs[i].exp_wr) running++;
    end

    in_valid = 1'b0;
    tick;
    chk("drain out_valid", out_valid, 0);
    chk("drain retire_count", retire_count, running);
    chk("drain sat retire_count", s_retire_count, 3);

    // reset clears the sticky flags and the counter
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst2 sel_err", sel_err, 0);
    chk("rst2 misalign_err", misalign_err, 0);
    chk("rst2 retire_count", retire_count, 0);

    // backpressure: first beat held, second beat waits at the input
    out_ready        = 1'b0;
    in_valid         = 1'b1;
    result_src       = 2'd2;
    reg_write_in     = 1'b1;
    src_data[95:64]  = 32'hAAAA0001;
    rd_in            = 5'd10;
    tick;
    chk("bp b1 result", result, 32'hAAAA0001);
    chk("bp b1 out_valid", out_valid, 1);
    chk("bp b1 in_ready", in_ready, 0);
    src_data[95:64] = 32'hAAAA0002;
    rd_in           = 5'd11;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("bp hold%0d result", k), result, 32'hAAAA0001);
      chk($sformatf("bp hold%0d rd_out", k), rd_out, 10);
      chk($sformatf("bp hold%0d in_ready", k), in_ready, 0);
      chk($sformatf("bp hold%0d retire_count", k), retire_count, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", in_ready, 1);
    tick;
    chk("bp b2 result", result, 32'hAAAA0002);
    chk("bp b2 rd_out", rd_out, 11);
    chk("bp b2 retire_count", retire_count, 1);
    src_data[95:64] = 32'hAAAA0003;
    rd_in           = 5'd12;
    tick;
    chk("bp b3 result", result, 32'hAAAA0003);
    chk("bp b3 rd_out", rd_out, 12);
    chk("bp b3 retire_count", retire_count, 2);
    in_valid = 1'b0;
    tick;
    chk("bp end out_valid", out_valid, 0);
    chk("bp end retire_count", retire_count, 3);
    chk("bp end sat retire_count", s_retire_count, 3);

    // flush drops the held beat and an illegal incoming beat without effects
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    result_src = 2'd0;
    rd_in      = 5'd20;
    tick;
    chk("fl held out_valid", out_valid, 1);
    flush      = 1'b1;
    result_src = 2'd3;
    tick;
    chk("fl out_valid", out_valid, 0);
    chk("fl retire_count", retire_count, 3);
    chk("fl sel_err", sel_err, 0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("fl after out_valid", out_valid, 0);
    chk("fl after retire_count", retire_count, 3);

    // handoff in the same cycle as flush still counts
    in_valid        = 1'b1;
    result_src      = 2'd2;
    src_data[95:64] = 32'hBBBB0001;
    rd_in           = 5'd21;
    tick;
    chk("flho held out_valid", out_valid, 1);
    chk("flho held result", result, 32'hBBBB0001);
    flush    = 1'b1;
    in_valid = 1'b0;
    tick;
    chk("flho out_valid", out_valid, 0);
    chk("flho retire_count", retire_count, 4);
    chk("flho sat retire_count", s_retire_count, 3);
    flush = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_wb_stage.md
Name: result_wb_stage

Overview:
- Parametrised writeback result stage for the multicycle RISC-V core. Successor to the fixed 3-input result select.
- Selects one of NUM_SRC source words and applies RISC-V load extraction/extension when the load source is selected.
- Registers the result with destination-register tag under a valid/ready handshake.
- Adds flush, illegal-select/misalign error flags and a saturating retire counter.

Parameters:
- WIDTH, 32, datapath width; legal values 32 or 64.
- NUM_SRC, 4, number of selectable sources, 2..8.
- LOAD_SRC, 1, source index carrying raw memory data, subject to load extraction.
- CNT_W, 16, retire counter width.
- SEL_W, $clog2(NUM_SRC), select width (derived).
- OFF_W, $clog2(WIDTH/8), byte-offset width (derived).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous discard of held and incoming beat
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- result_src  in  SEL_W  source select
- src_data  in  NUM_SRC*WIDTH  packed sources, source i at bits [i*WIDTH +: WIDTH]
- funct3  in  3  load type, used only when result_src==LOAD_SRC
- byte_off  in  OFF_W  load address low bits
- rd_in  in  5  destination register
- reg_write_in  in  1  writeback enable
- out_valid  out  1  held beat valid
- out_ready  in  1  consumer accepts held beat
- result  out  WIDTH  registered result
- rd_out  out  5  registered rd
- reg_write_out  out  1  registered writeback enable
- sel_err  out  1  sticky: illegal result_src accepted
- misalign_err  out  1  sticky: misaligned load accepted
- retire_count  out  CNT_W  saturating count of completed writebacks

Behaviour:
- Reset (synchronous, active-high, highest priority): out_valid=0, result=0, rd_out=0, reg_write_out=0, sel_err=0, misalign_err=0, retire_count=0. in_ready is 1 in the cycle after reset.
- in_ready is combinational: !out_valid || out_ready.
- Capture occurs when in_valid && in_ready && !flush. Captured data appears on outputs the next cycle, giving 1-cycle latency.
- Full-throughput: back-to-back captures are allowed while out_ready=1.
- out_valid next state, in priority order:
  - flush → 0
  - capture → 1
  - out_ready → 0
  - otherwise hold
- Held result, rd_out and reg_write_out stay stable while out_valid && !out_ready.
- Select, when result_src < NUM_SRC and result_src != LOAD_SRC: result = src_data[result_src].
- Select, when result_src >= NUM_SRC: captured result=0 and reg_write_out=0. sel_err sets on capture.
- Load extraction (result_src==LOAD_SRC), with word w = src_data[LOAD_SRC] and byte lane b = byte_off:
  - 000 LB: sign-extend w byte b.
  - 100 LBU: zero-extend w byte b.
  - 001 LH: sign-extend halfword at b; b must be even.
  - 101 LHU: zero-extend halfword at b; b must be even.
  - 010 LW: low 32 bits at b; sign-extended when WIDTH=64; b must be a multiple of 4.
  - 110 LWU (WIDTH=64 only): as LW, zero-extended.
  - 011 LD (WIDTH=64 only): full word; b must be 0.
  - Any other funct3, or a 64-only code with WIDTH=32: treated as misaligned.
- Misaligned or illegal load: captured result=0, reg_write_out=0, misalign_err sets on capture.
- Sticky flags are cleared only by reset. Flags do not set when the capture is suppressed by flush.
- retire_count increments by 1 on each out_valid && out_ready && reg_write_out. It saturates at 2^CNT_W-1.
- A flushed held beat never counts. A beat handed off in the same cycle as flush does count: the handshake completes, then valid clears.
- rd_out == 0 with reg_write_out=1 is passed through unchanged; x0 suppression is the register file's job.

Test Plan:
- Reset with in_valid=1, src_data[0]=0x1234: reset high 2 cycles → outputs 0, out_valid=0. First edge after reset deasserts with in_valid=1, src 0 → result=0x00001234, out_valid=1 next cycle.
- WIDTH=32, LOAD_SRC word 0x80FF7F01:
  - LB off 1 → 0x0000007F.
  - LB off 3 → 0xFFFFFF80.
  - LBU off 3 → 0x00000080.
  - LH off 2 → 0xFFFF80FF.
  - LH off 1 → result 0, reg_write_out=0, misalign_err=1.
- Backpressure: out_ready=0 with 3 beats offered → first held stable, in_ready=0, later beats not captured. Set out_ready=1 → beats retire in order, one per cycle, retire_count=3.
- Illegal select: NUM_SRC=3, result_src=3 → result=0, reg_write_out=0, sel_err=1 and stays 1 after further legal beats.
- Flush: flush=1 while holding a beat with out_ready=0 and a new in_valid beat → next cycle out_valid=0, neither beat appears, retire_count unchanged.
- Saturation: CNT_W=2, 5 writebacks → retire_count stops at 3.
